// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential digit-serial comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, minimum legal WIDTH/DIGIT values, legality helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MIN_DIGIT = 1;

    // WIDTH must split into a whole number of DIGIT-bit digits.
    function automatic bit params_legal(input int width, input int digit);
        if (digit < MIN_DIGIT || width < MIN_WIDTH)
            return 1'b0;
        return (width % digit) == 0;
    endfunction

endpackage

// File: rtl/seq_comparator_if.sv
// Handshake/operand/result bundle between a compare requester and seq_comparator.
// Latency: n/a (wiring only).
// Backpressure: requester must only expect start to be taken while busy is low.
// Signals: start, a, b, signed_mode (requester -> comparator);
//          busy, done, a_gt_b, b_gt_a, a_eq_b (comparator -> requester).
interface seq_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             b_gt_a;
    logic             a_eq_b;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, a_gt_b, b_gt_a, a_eq_b
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, a_gt_b, b_gt_a, a_eq_b
    );
endinterface

// File: rtl/cmp_digit.sv
// Combinational magnitude compare of one DIGIT-bit digit pair.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: x, y (digits in); gt (x>y), lt (x<y), eq (x==y).
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = (x > y);
    assign lt = (x < y);
    assign eq = (x == y);
endmodule

// File: rtl/seq_comparator.sv
// Digit-serial MSB-first comparator (signed or unsigned), DIGIT bits per cycle, early exit.
// Latency: done d+1 cycles after start is taken, d = first differing digit (WIDTH/DIGIT if equal).
// Backpressure: start is only taken in IDLE (busy=0); requests while busy are dropped.
// Ports: clk, rst (sync, active-high); bus = seq_comparator_if.slave (start/a/b/signed_mode in,
//        busy/done/a_gt_b/b_gt_a/a_eq_b out; flags hold until the next accepted start).
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    seq_comparator_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    if (!params_legal(WIDTH, DIGIT)) begin : g_illegal
        $error("seq_comparator: WIDTH must be >= 2 and a multiple of DIGIT (DIGIT >= 1)");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;
    logic             busy;
    logic             done;
    logic             dig_gt;
    logic             dig_lt;
    logic             dig_eq;
    logic             last_dig;

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .x  (sh_a[WIDTH-1 -: DIGIT]),
        .y  (sh_b[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    assign last_dig = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = COMPARE;
            end
            COMPARE: begin
                busy = 1'b1;
                if (!dig_eq || last_dig)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flipping both MSBs maps two's-complement order onto unsigned order,
    // so a single unsigned MSB-first scan serves both modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
            cnt  <= '0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                        sh_b <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                        cnt  <= NDIG[CW-1:0];
                        gt_q <= 1'b0;
                        lt_q <= 1'b0;
                        eq_q <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (dig_gt) begin
                        gt_q <= 1'b1;
                    end else if (dig_lt) begin
                        lt_q <= 1'b1;
                    end else if (last_dig) begin
                        eq_q <= 1'b1;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        cnt  <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.a_gt_b = gt_q;
    assign bus.b_gt_a = lt_q;
    assign bus.a_eq_b = eq_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator (WIDTH=8, DIGIT=2): directed table, corner sequences,
// and random compares against an arithmetic reference model.
// Flags are compared as the 3-bit vector {a_gt_b, b_gt_a, a_eq_b}.
module tb_seq_comparator;
    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;

    logic clk;
    logic rst;
    int   total;
    int   pass_cnt;

    seq_comparator_if #(.WIDTH(W)) bus ();

    seq_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [2:0]   flags;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected flags from plain signed/unsigned arithmetic.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
        if (sm)
            return {$signed(x) > $signed(y), $signed(x) < $signed(y), x == y};
        return {x > y, x < y, x == y};
    endfunction

    // Expected cycles from start-sample to done: d+1, where d is the
    // shortest MSB prefix (in whole digits) on which the operands differ.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 1; i <= NDIG; i++) begin
            if ((x >> (W - D * i)) != (y >> (W - D * i)))
                return i + 1;
        end
        return NDIG + 1;
    endfunction

    // Issue one compare from IDLE; returns flags at done and cycle offset of
    // done relative to the start-sample cycle (-1 on timeout). Ends in IDLE.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                           output logic [2:0] fl, output int lat);
        bus.a           = ta;
        bus.b           = tb_v;
        bus.signed_mode = tsm;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        fl  = 3'b000;
        for (int n = 1; n <= 40; n++) begin
            if (bus.done) begin
                lat = n;
                fl  = {bus.a_gt_b, bus.b_gt_a, bus.a_eq_b};
                break;
            end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [2:0]   fl;
        int           lat;
        logic [W-1:0] ra, rb;
        logic         rsm;

        total    = 0;
        pass_cnt = 0;

        //           a      b      sm    {gt,lt,eq} lat
        vecs[0] = '{8'hA5, 8'h25, 1'b0, 3'b100, 2};
        vecs[1] = '{8'h3C, 8'h3C, 1'b0, 3'b001, 5};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 3'b010, 2};
        vecs[3] = '{8'h80, 8'h7F, 1'b0, 3'b100, 2};
        vecs[4] = '{8'h12, 8'h13, 1'b0, 3'b010, 5};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 3'b010, 2};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 3'b001, 5};
        vecs[7] = '{8'h7F, 8'h80, 1'b1, 3'b100, 2};
        vecs[8] = '{8'hFE, 8'hFF, 1'b1, 3'b010, 5};
        vecs[9] = '{8'h41, 8'h40, 1'b0, 3'b100, 5};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_flags", int'({bus.a_gt_b, bus.b_gt_a, bus.a_eq_b}), 0);

        // start coincident with rst must be dropped
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("start_in_rst_busy", int'(bus.busy), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst_busy", int'(bus.busy), 0);

        foreach (vecs[i]) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, fl, lat);
            check($sformatf("vec%0d_flags", i), int'(fl), int'(vecs[i].flags));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_idle", i), int'(bus.busy), 0);
        end

        // flags hold across idle cycles until the next start
        run_cmp(8'h3C, 8'h3C, 1'b0, fl, lat);
        bus.a = 8'hF0;
        bus.b = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("hold_flags", int'({bus.a_gt_b, bus.b_gt_a, bus.a_eq_b}), 3'b001);
        check("hold_done", int'(bus.done), 0);

        // start held high (with changing operands) while busy and in DONE is ignored;
        // start in the following IDLE cycle is accepted back-to-back
        bus.a           = 8'h12;
        bus.b           = 8'h13;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        check("busy_start_lat", lat, 5);
        check("busy_start_flags", int'({bus.a_gt_b, bus.b_gt_a, bus.a_eq_b}), 3'b010);
        @(posedge clk); #1;
        check("after_done_idle", int'(bus.busy), 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_accepted", int'(bus.busy), 1);
        @(posedge clk); #1;
        check("b2b_done", int'(bus.done), 1);
        check("b2b_flags", int'({bus.a_gt_b, bus.b_gt_a, bus.a_eq_b}), 3'b100);
        @(posedge clk); #1;

        // reset in the second COMPARE cycle
        bus.a     = 8'h12;
        bus.b     = 8'h13;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_flags", int'({bus.a_gt_b, bus.b_gt_a, bus.a_eq_b}), 0);
        run_cmp(8'h7F, 8'h80, 1'b1, fl, lat);
        check("postrst_flags", int'(fl), 3'b100);
        check("postrst_lat", lat, 2);

        // random compares against the reference model
        for (int i = 0; i < 200; i++) begin
            ra  = W'($urandom);
            rb  = (($urandom % 4) == 0) ? (ra ^ W'(1 << ($urandom % W))) : W'($urandom);
            rsm = 1'($urandom);
            if (($urandom % 8) == 0)
                rb = ra;
            run_cmp(ra, rb, rsm, fl, lat);
            check($sformatf("rnd%0d_flags", i), int'(fl), int'(ref_flags(ra, rb, rsm)));
            check($sformatf("rnd%0d_lat", i), lat, ref_lat(ra, rb));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be >= 2 and a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 2: bits examined per cycle; SHALL be >= 1.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a compare; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-009 busy  output  1  high while a compare is in progress.
REQ-010 done  output  1  one-cycle pulse marking valid result flags.
REQ-011 a_gt_b  output  1  registered, A > B.
REQ-012 b_gt_a  output  1  registered, B > A.
REQ-013 a_eq_b  output  1  registered, A == B.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COMPARE, DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and signed_mode, load the digit counter with WIDTH/DIGIT, clear all three flags, and enter COMPARE.
REQ-016 In signed mode, the MSB of both latched operands SHALL be inverted so that one unsigned MSB-first compare yields the signed result.
REQ-017 Each COMPARE cycle SHALL compare the top DIGIT bits of both shift registers, MSB-first.
REQ-018 If the digits differ, the block SHALL register a_gt_b or b_gt_a and enter DONE (early exit).
REQ-019 If the digits are equal and more digits remain, the block SHALL shift both registers left by DIGIT, decrement the counter and stay in COMPARE.
REQ-020 If the digits are equal on the last digit, the block SHALL register a_eq_b=1 and enter DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in COMPARE and DONE, and 0 in IDLE.
REQ-023 Latency: with start sampled in cycle k and the first differing digit at index d (1..WIDTH/DIGIT; d = WIDTH/DIGIT if equal), done SHALL be high in cycle k+d+1.
REQ-024 The flags SHALL hold their value from DONE until the next accepted start; exactly one flag SHALL be high whenever done=1.
REQ-025 start SHALL be ignored in COMPARE and DONE; operand changes while busy SHALL have no effect.
REQ-026 start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back period of d+2 cycles.

Reset
REQ-027 rst=1 SHALL force IDLE from any state, including mid-COMPARE, with busy=0, done=0, all flags 0, and the counter and shift registers cleared.
REQ-028 start coincident with rst SHALL be ignored; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 A shared package cmp_pkg SHALL hold the FSM state enum and the parameter-legality check constants.
REQ-030 A combinational sub-module cmp_digit (parameter DIGIT; outputs gt, lt, eq) SHALL perform the per-cycle digit compare.
REQ-031 Illegal WIDTH/DIGIT combinations SHALL cause an elaboration-time error.

Verification (WIDTH=8, DIGIT=2)
REQ-032 Unsigned a=0xA5, b=0x25, start in cycle k -> a_gt_b=1 and done in cycle k+2.
REQ-033 Unsigned a=0x3C, b=0x3C -> a_eq_b=1 and done in cycle k+5; flags hold until the next start.
REQ-034 a=0x80, b=0x7F: signed_mode=1 -> b_gt_a=1; signed_mode=0 -> a_gt_b=1.
REQ-035 a=0x12, b=0x13 -> b_gt_a=1, done in cycle k+5.
REQ-036 start pulsed while busy and during the DONE cycle -> ignored; start in the next IDLE cycle -> accepted.
REQ-037 rst in the second COMPARE cycle -> the next cycle shows busy=0, done=0 and all flags 0; a subsequent compare gives the correct result.
